// File: rtl/randomizer_ctrl_pkg.sv
// Shared types and constants for the 802.16 OFDM randomizer burst sequencer.
package randomizer_pkg;

    localparam int IV_W = 15;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DRAIN
    } state_t;

    localparam logic [7:0]      PAD_BYTE        = 8'hFF;
    localparam logic [IV_W-1:0] RAND_IV_DEFAULT = 15'h3715;

endpackage

// File: rtl/randomizer_ctrl_if.sv
// Descriptor, byte-stream, randomizer and FEC-side signals of the sequencer.
// pad_inserted exists only when RANDCTRL_PAD_EN is defined.
interface randomizer_ctrl_if #(
    parameter int LEN_W = 11
);
    import randomizer_pkg::*;

    logic             burst_start;
    logic [LEN_W-1:0] burst_len;
    logic [IV_W-1:0]  burst_iv;
    logic             burst_ready;
    logic             burst_done;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;
    logic [IV_W-1:0]  rand_iv;
    logic             reload;
    logic             rnd_in_bit;
    logic             rnd_in_valid;
    logic             rnd_out_bit;
    logic             rnd_out_valid;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_last;
`ifdef RANDCTRL_PAD_EN
    logic             pad_inserted;
`endif

    modport slave (
        input  burst_start, burst_len, burst_iv, byte_data, byte_valid,
               rnd_out_bit, rnd_out_valid,
        output burst_ready, burst_done, byte_ready, rand_iv, reload,
               rnd_in_bit, rnd_in_valid, out_data, out_valid, out_last
`ifdef RANDCTRL_PAD_EN
        , output pad_inserted
`endif
    );

    modport master (
        output burst_start, burst_len, burst_iv, byte_data, byte_valid,
               rnd_out_bit, rnd_out_valid,
        input  burst_ready, burst_done, byte_ready, rand_iv, reload,
               rnd_in_bit, rnd_in_valid, out_data, out_valid, out_last
`ifdef RANDCTRL_PAD_EN
        , input pad_inserted
`endif
    );

endinterface

// File: rtl/randomizer_ctrl_pack.sv
// Repacks randomized bits MSB-first into bytes, counting bytes per burst
// so the sequencer can flag the last one and know when the burst has drained.
module randomizer_ctrl_pack
    import randomizer_pkg::*;
#(
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             bit_i,
    input  logic             valid_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    output logic             last_o,
    output logic [LEN_W-1:0] count_o
);

    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       bits_q, bits_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [LEN_W-1:0] count_q, count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            bits_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            shreg_q <= shreg_d;
            bits_q  <= bits_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // Clear happens during the reload cycle, before any bit of the new burst.
    always_comb begin
        shreg_d = shreg_q;
        bits_d  = bits_q;
        data_d  = data_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        count_d = count_q;
        if (clear_i) begin
            shreg_d = '0;
            bits_d  = '0;
            count_d = '0;
        end else if (valid_i) begin
            shreg_d = {shreg_q[6:0], bit_i};
            bits_d  = bits_q + 3'd1;
            if (bits_q == 3'd7) begin
                data_d  = {shreg_q[6:0], bit_i};
                valid_d = 1'b1;
                count_d = count_q + LEN_W'(1);
                last_d  = ((count_q + LEN_W'(1)) == len_i);
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign count_o = count_q;

endmodule

// File: rtl/randomizer_ctrl.sv
// Burst sequencer for the 802.16 OFDM randomizer: reload IV, serialize bytes
// MSB-first at one bit per clock, then wait for the packer to drain.
// Optional pad insertion after PAD_TIMEOUT idle cycles: define RANDCTRL_PAD_EN.
module randomizer_ctrl
    import randomizer_pkg::*;
#(
    parameter int LEN_W = 11
`ifdef RANDCTRL_PAD_EN
    , parameter int PAD_TIMEOUT = 16
`endif
) (
    input logic              clk,
    input logic              reset,
    randomizer_ctrl_if.slave bus
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IV_W-1:0]  iv_q, iv_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [3:0]       bitCnt_q, bitCnt_d;
    logic [LEN_W-1:0] acc_q, acc_d;
    logic             byteReady, rndValid, done;
    logic             packValid;
    logic [LEN_W-1:0] packCount;
`ifdef RANDCTRL_PAD_EN
    localparam int IDLE_W = (PAD_TIMEOUT > 1) ? $clog2(PAD_TIMEOUT) : 1;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              padFire;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            iv_q     <= '0;
            shreg_q  <= '0;
            bitCnt_q <= '0;
            acc_q    <= '0;
`ifdef RANDCTRL_PAD_EN
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            iv_q     <= iv_d;
            shreg_q  <= shreg_d;
            bitCnt_q <= bitCnt_d;
            acc_q    <= acc_d;
`ifdef RANDCTRL_PAD_EN
            idle_q   <= idle_d;
`endif
        end
    end

    // A new byte may load while the last bit of the previous one is still
    // on the wire, which keeps back-to-back bytes bubble-free.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        iv_d      = iv_q;
        shreg_d   = shreg_q;
        bitCnt_d  = bitCnt_q;
        acc_d     = acc_q;
        byteReady = 1'b0;
        done      = 1'b0;
        rndValid  = (state_q == SHIFT) && (bitCnt_q != 4'd0);
`ifdef RANDCTRL_PAD_EN
        idle_d    = '0;
        padFire   = 1'b0;
`endif
        if (rndValid) begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            bitCnt_d = bitCnt_q - 4'd1;
        end
        case (state_q)
            IDLE: begin
                if (bus.burst_start && (bus.burst_len != '0)) begin
                    len_d   = bus.burst_len;
                    iv_d    = bus.burst_iv;
                    acc_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = SHIFT;
            SHIFT: begin
                byteReady = (acc_q != len_q) && (bitCnt_q <= 4'd1);
                if (byteReady && bus.byte_valid) begin
                    shreg_d  = bus.byte_data;
                    bitCnt_d = 4'd8;
                    acc_d    = acc_q + LEN_W'(1);
                end
`ifdef RANDCTRL_PAD_EN
                else if ((bitCnt_q == 4'd0) && (acc_q != len_q)) begin
                    if (idle_q == IDLE_W'(PAD_TIMEOUT - 1)) begin
                        padFire  = 1'b1;
                        shreg_d  = PAD_BYTE;
                        bitCnt_d = 4'd8;
                        acc_d    = acc_q + LEN_W'(1);
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
`endif
                if ((acc_q == len_q) && (bitCnt_q == 4'd1)) state_d = DRAIN;
            end
            DRAIN: begin
                if ((packCount == len_q) && !packValid) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    randomizer_ctrl_pack #(.LEN_W(LEN_W)) u_pack (
        .clk     (clk),
        .reset   (reset),
        .clear_i (state_q == LOAD),
        .bit_i   (bus.rnd_out_bit),
        .valid_i (bus.rnd_out_valid),
        .len_i   (len_q),
        .data_o  (bus.out_data),
        .valid_o (packValid),
        .last_o  (bus.out_last),
        .count_o (packCount)
    );

    assign bus.out_valid    = packValid;
    assign bus.burst_ready  = (state_q == IDLE);
    assign bus.burst_done   = done;
    assign bus.byte_ready   = byteReady;
    assign bus.rand_iv      = iv_q;
    assign bus.reload       = (state_q == LOAD);
    assign bus.rnd_in_bit   = rndValid & shreg_q[7];
    assign bus.rnd_in_valid = rndValid;
`ifdef RANDCTRL_PAD_EN
    assign bus.pad_inserted = padFire;
`endif

endmodule
